// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Each accepted request takes three cycles: grant/execute, response, return to idle.
module alu_arbiter #(
   parameter int DWIDTH  = 16,
   parameter int OPW     = 4,
   parameter int NUM_OPS = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [OPW-1:0]    op0,
   input  logic [DWIDTH-1:0] a0,
   input  logic [DWIDTH-1:0] b0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [OPW-1:0]    op1,
   input  logic [DWIDTH-1:0] a1,
   input  logic [DWIDTH-1:0] b1,
   output logic              gnt1,
   output logic [DWIDTH-1:0] alu_operand1,
   output logic [DWIDTH-1:0] alu_operand2,
   output logic [3:0]        alu_operation,
   input  logic [DWIDTH-1:0] alu_dout,
   input  logic              alu_nz,
   output logic              resp_valid,
   output logic              resp_id,
   output logic [DWIDTH-1:0] resp_data,
   output logic              resp_zero,
   output logic              resp_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              win_id_q, win_id_d;
   logic [OPW-1:0]    op_q, op_d;
   logic [DWIDTH-1:0] a_q, a_d;
   logic [DWIDTH-1:0] b_q, b_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_id_q, resp_id_d;
   logic [DWIDTH-1:0] resp_data_q, resp_data_d;
   logic              resp_zero_q, resp_zero_d;
   logic              resp_err_q, resp_err_d;

   logic any_req;
   logic winner;
   logic op_legal;

   // On a tie the requester that did not win last time gets the ALU.
   always_comb begin
      any_req = req0 | req1;
      if (req0 && req1) begin
         winner = ~last_grant_q;
      end else begin
         winner = req1;
      end
      op_legal = (op_q < OPW'(NUM_OPS));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         win_id_q     <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_data_q  <= '0;
         resp_zero_q  <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         win_id_q     <= win_id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_data_q  <= resp_data_d;
         resp_zero_q  <= resp_zero_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Requests arriving in EXEC or RESP are left pending on the req lines.
   always_comb begin
      last_grant_d = last_grant_q;
      win_id_d     = win_id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      resp_valid_d = 1'b0;
      resp_id_d    = resp_id_q;
      resp_data_d  = resp_data_q;
      resp_zero_d  = resp_zero_q;
      resp_err_d   = resp_err_q;
      if (state_q == IDLE && any_req) begin
         win_id_d     = winner;
         last_grant_d = winner;
         op_d         = winner ? op1 : op0;
         a_d          = winner ? a1 : a0;
         b_d          = winner ? b1 : b0;
         gnt0_d       = ~winner;
         gnt1_d       = winner;
      end
      if (state_q == EXEC) begin
         resp_valid_d = 1'b1;
         resp_id_d    = win_id_q;
         if (op_legal) begin
            resp_data_d = alu_dout;
            resp_zero_d = ~alu_nz;
            resp_err_d  = 1'b0;
         end else begin
            resp_data_d = '0;
            resp_zero_d = 1'b0;
            resp_err_d  = 1'b1;
         end
      end
   end

   // Illegal opcodes are replaced by 0 so the ALU output is always driven.
   always_comb begin
      busy          = (state_q != IDLE);
      alu_operand1  = '0;
      alu_operand2  = '0;
      alu_operation = 4'b0000;
      if (state_q == EXEC) begin
         alu_operand1 = a_q;
         alu_operand2 = b_q;
         if (op_legal) begin
            alu_operation = 4'(op_q);
         end
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_zero  = resp_zero_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_alu_arbiter;

   localparam int DW   = 16;
   localparam int OPW  = 4;
   localparam int NOPS = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0, req1;
   logic [OPW-1:0] op0, op1;
   logic [DW-1:0] a0, b0, a1, b1;
   logic          gnt0, gnt1;
   logic [DW-1:0] alu_operand1, alu_operand2;
   logic [3:0]    alu_operation;
   logic [DW-1:0] alu_dout;
   logic          alu_nz;
   logic          resp_valid, resp_id, resp_zero, resp_err, busy;
   logic [DW-1:0] resp_data;

   logic          req_v [2];
   logic [3:0]    op_v  [2];
   logic [15:0]   a_v   [2];
   logic [15:0]   b_v   [2];

   int checks = 0;
   int failures = 0;

   // Reference model state
   int          blocked;
   bit          resp_next;
   bit          last_grant;
   logic [15:0] pend_data, held_data;
   bit          pend_zero, held_zero, pend_err, held_err, pend_id;
   bit          gnt_seen [2];
   int          cyc;
   int          obs_win [$];
   int          obs_cyc [$];

   always #5 clk = ~clk;

   assign req0 = req_v[0];
   assign op0  = op_v[0];
   assign a0   = a_v[0];
   assign b0   = b_v[0];
   assign req1 = req_v[1];
   assign op1  = op_v[1];
   assign a1   = a_v[1];
   assign b1   = b_v[1];

   alu_arbiter #(.DWIDTH(DW), .OPW(OPW), .NUM_OPS(NOPS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
      .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
      .alu_operation(alu_operation), .alu_dout(alu_dout), .alu_nz(alu_nz),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy)
   );

   // Behavioural ALU: pass, add, sub, shl1, and, shr4, inc
   function automatic logic [15:0] refAlu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         4'd0:    refAlu = a;
         4'd1:    refAlu = a + b;
         4'd2:    refAlu = a - b;
         4'd3:    refAlu = a << 1;
         4'd4:    refAlu = a & b;
         4'd5:    refAlu = a >> 4;
         4'd6:    refAlu = a + 16'd1;
         default: refAlu = 16'hDEAD;
      endcase
   endfunction

   assign alu_dout = refAlu(alu_operation, alu_operand1, alu_operand2);
   assign alu_nz   = |alu_dout;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic resetModel();
      blocked    = 0;
      resp_next  = 0;
      last_grant = 1;
      held_data  = 16'h0;
      held_zero  = 0;
      held_err   = 0;
      gnt_seen[0] = 0;
      gnt_seen[1] = 0;
   endtask

   // Pulses reset from the current point in the cycle and checks the outputs clear at once.
   task automatic resetDut();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_gnt0", gnt0, 0);
      checkOutput("rst_gnt1", gnt1, 0);
      checkOutput("rst_valid", resp_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_data", resp_data, 0);
      checkOutput("rst_flags", {resp_id, resp_zero, resp_err}, 0);
      checkOutput("rst_aluop", alu_operation, 0);
      checkOutput("rst_opnds", {alu_operand1, alu_operand2}, 0);
      resetModel();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advances one clock and compares every output with the model's expectation.
   task automatic stepCycle();
      bit          accept, win, ex_valid, ill;
      logic [15:0] ex_a, ex_b;
      logic [3:0]  ex_op, op;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      accept = 0; win = 0; ex_valid = 0;
      ex_a = 0; ex_b = 0; ex_op = 0;
      gnt_seen[0] = 0;
      gnt_seen[1] = 0;
      if (blocked > 0) begin
         blocked--;
      end else if (req_v[0] || req_v[1]) begin
         accept = 1;
         win = (req_v[0] && req_v[1]) ? ~last_grant : req_v[1];
         last_grant = win;
         op   = op_v[win];
         ex_a = a_v[win];
         ex_b = b_v[win];
         ill  = (op >= NOPS);
         ex_op     = ill ? 4'd0 : op;
         pend_err  = ill;
         pend_data = ill ? 16'h0 : refAlu(op, ex_a, ex_b);
         pend_zero = !ill && (pend_data == 16'h0);
         pend_id   = win;
         resp_next = 1;
         blocked   = 2;
         gnt_seen[win] = 1;
      end
      if (!accept && resp_next) begin
         ex_valid  = 1;
         resp_next = 0;
         held_data = pend_data;
         held_zero = pend_zero;
         held_err  = pend_err;
      end
      if (gnt0) begin obs_win.push_back(0); obs_cyc.push_back(cyc); end
      if (gnt1) begin obs_win.push_back(1); obs_cyc.push_back(cyc); end
      checkOutput("gnt0", gnt0, accept && !win);
      checkOutput("gnt1", gnt1, accept && win);
      checkOutput("resp_valid", resp_valid, ex_valid);
      checkOutput("busy", busy, accept || ex_valid);
      checkOutput("alu_operation", alu_operation, ex_op);
      checkOutput("alu_operands", {alu_operand1, alu_operand2}, {ex_a, ex_b});
      checkOutput("resp_data", resp_data, held_data);
      checkOutput("resp_flags", {resp_zero, resp_err}, {held_zero, held_err});
      if (ex_valid) checkOutput("resp_id", resp_id, pend_id);
   endtask

   // Issues one request, waits (bounded) for its grant, then lets the response complete.
   task automatic applyStimulus(input int id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      bit got;
      req_v[id] = 1; op_v[id] = op; a_v[id] = a; b_v[id] = b;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         stepCycle();
         got = gnt_seen[id];
      end
      if (!got) checkOutput("grant_timeout", 0, 1);
      req_v[id] = 0;
      stepCycle();
      stepCycle();
   endtask

   task automatic randomize_req(input int k);
      op_v[k] = 4'($urandom_range(0, 9));
      a_v[k]  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      b_v[k]  = ($urandom_range(0, 3) == 0) ? a_v[k] : 16'($urandom);
   endtask

   initial begin
      bit got;
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
         req_v[k] = 0; op_v[k] = 0; a_v[k] = 0; b_v[k] = 0;
      end
      resetDut();

      applyStimulus(0, 4'd1, 16'h0003, 16'h0004);
      checkOutput("add_data", resp_data, 16'h0007);
      checkOutput("add_flags", {resp_id, resp_zero, resp_err}, 3'b000);
      applyStimulus(1, 4'd2, 16'h0005, 16'h0005);
      checkOutput("sub_zero_data", resp_data, 16'h0000);
      checkOutput("sub_zero_flags", {resp_id, resp_zero, resp_err}, 3'b110);
      applyStimulus(1, 4'd2, 16'h0000, 16'h0001);
      checkOutput("sub_wrap_data", resp_data, 16'hFFFF);
      checkOutput("sub_wrap_zero", resp_zero, 0);
      applyStimulus(0, 4'hA, 16'h1234, 16'h5678);
      checkOutput("illegal_flags", {resp_zero, resp_err}, 2'b01);
      checkOutput("illegal_data", resp_data, 16'h0000);
      applyStimulus(0, 4'd3, 16'h8001, 16'h0000);
      checkOutput("shl_data", resp_data, 16'h0002);
      applyStimulus(1, 4'd5, 16'hABCD, 16'h0000);
      checkOutput("shr_data", resp_data, 16'h0ABC);
      applyStimulus(0, 4'd6, 16'hFFFF, 16'h0000);
      checkOutput("inc_wrap", {resp_data, 15'h0, resp_zero}, {16'h0000, 15'h0, 1'b1});

      // Both requesters held high from reset: grants must alternate three cycles apart
      req_v[0] = 1; op_v[0] = 4'd1; a_v[0] = 16'd10; b_v[0] = 16'd20;
      req_v[1] = 1; op_v[1] = 4'd2; a_v[1] = 16'd30; b_v[1] = 16'd7;
      resetDut();
      obs_win.delete();
      obs_cyc.delete();
      for (int i = 0; i < 13; i++) begin
         stepCycle();
         for (int k = 0; k < 2; k++) if (gnt_seen[k]) begin
            op_v[k] = 4'($urandom_range(0, 6));
            a_v[k]  = 16'($urandom);
         end
      end
      checkOutput("tie_count", obs_win.size(), 5);
      for (int i = 0; i < obs_win.size(); i++) begin
         checkOutput("tie_order", obs_win[i], i % 2);
         if (i > 0) checkOutput("tie_spacing", obs_cyc[i] - obs_cyc[i-1], 3);
      end

      // Reset during EXEC aborts the transaction; next tie goes to requester 0
      got = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         stepCycle();
         got = gnt_seen[0] || gnt_seen[1];
      end
      if (!got) checkOutput("abort_grant_timeout", 0, 1);
      resetDut();
      obs_win.delete();
      obs_cyc.delete();
      for (int i = 0; i < 4; i++) stepCycle();
      checkOutput("post_reset_first_winner", (obs_win.size() > 0) ? obs_win[0] : 9, 0);
      req_v[0] = 0;
      req_v[1] = 0;
      for (int i = 0; i < 3; i++) stepCycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (gnt_seen[k]) begin
               if ($urandom_range(0, 1) == 0) randomize_req(k);
               else req_v[k] = 0;
            end else if (!req_v[k] && $urandom_range(0, 2) == 0) begin
               req_v[k] = 1;
               randomize_req(k);
            end
         end
         stepCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout cycle=%0d observed=running expected=finished", cyc);
      $fatal(1, "[TB] timeout");
   end

endmodule
